sccb_master: RTL

SCCB_MASTER -- requirements
Module: sccb_master

---
 rtl/sccb_master.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sccb_master.sv
// SCCB (two-wire camera control bus) master: single-byte register write and
// two-phase register read, every bus event built from fixed SIO_C segments.
module sccb_master #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SCL_DIV = 500,
    parameter logic [7:0]  DEV_ID  = 8'h42
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              sio_c,
    output logic              sio_d_out,
    output logic              sio_d_en,
    input  logic              sio_d_in
);

    localparam int unsigned Q     = SCL_DIV / 4;
    localparam int unsigned CNT_W = $clog2(SCL_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WBYTE = 3'd2,
        RBYTE = 3'd3,
        STOP  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIT_W-1:0]    r_bit;
    logic [1:0]          r_byte;
    logic                r_ph2;
    logic                r_rd;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rdata_vld;
    logic                r_sio_c;
    logic                r_sio_d_out;
    logic                r_sio_d_en;

    state_t              w_nxt_state;
    logic [CNT_W-1:0]    w_nxt_cnt;
    logic [BIT_W-1:0]    w_nxt_bit;
    logic [1:0]          w_nxt_byte;
    logic                w_nxt_ph2;
    logic                w_accept;
    logic                w_seg_end;
    logic                w_last_byte;
    logic [DATA_W-1:0]   w_tx_byte;
    logic [DATA_W-1:0]   w_tx_shift;
    logic                w_tx_bit;
    logic                w_nxt_sio_c;
    logic                w_nxt_sio_d_out;
    logic                w_nxt_sio_d_en;

    assign rdy       = (r_state == IDLE) && !wr_en && !rd_en;
    assign rdata     = r_rdata;
    assign rdata_vld = r_rdata_vld;
    assign sio_c     = r_sio_c;
    assign sio_d_out = r_sio_d_out;
    assign sio_d_en  = r_sio_d_en;

    // Next-state sequencing, then bus levels derived from where the FSM lands next
    always_comb begin
        w_seg_end       = (r_cnt == CNT_W'(SCL_DIV - 1));
        w_nxt_state     = r_state;
        w_nxt_cnt       = w_seg_end ? '0 : r_cnt + CNT_W'(1);
        w_nxt_bit       = r_bit;
        w_nxt_byte      = r_byte;
        w_nxt_ph2       = r_ph2;
        w_accept        = 1'b0;
        w_last_byte     = r_rd ? (r_ph2 || (r_byte == 2'd1)) : (r_byte == 2'd2);
        w_nxt_sio_c     = r_sio_c;
        w_nxt_sio_d_out = r_sio_d_out;
        w_nxt_sio_d_en  = r_sio_d_en;

        case (r_state)
            IDLE: begin
                w_nxt_cnt = '0;
                if (wr_en || rd_en) begin
                    w_accept    = 1'b1;
                    w_nxt_state = START;
                    w_nxt_bit   = '0;
                    w_nxt_byte  = 2'd0;
                    w_nxt_ph2   = 1'b0;
                end
            end
            START: begin
                if (w_seg_end) begin
                    w_nxt_state = WBYTE;
                    w_nxt_bit   = '0;
                    w_nxt_byte  = 2'd0;
                end
            end
            WBYTE: begin
                if (w_seg_end) begin
                    if (r_bit == BIT_W'(DATA_W)) begin
                        w_nxt_bit = '0;
                        if (w_last_byte) begin
                            w_nxt_state = (r_rd && r_ph2) ? RBYTE : STOP;
                        end else begin
                            w_nxt_byte = r_byte + 2'd1;
                        end
                    end else begin
                        w_nxt_bit = r_bit + BIT_W'(1);
                    end
                end
            end
            RBYTE: begin
                if (w_seg_end) begin
                    if (r_bit == BIT_W'(DATA_W)) begin
                        w_nxt_bit   = '0;
                        w_nxt_state = STOP;
                    end else begin
                        w_nxt_bit = r_bit + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (w_seg_end) w_nxt_state = GAP;
            end
            GAP: begin
                if (w_seg_end) begin
                    if (r_rd && !r_ph2) begin
                        w_nxt_state = START;
                        w_nxt_ph2   = 1'b1;
                        w_nxt_byte  = 2'd0;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase

        // Byte being shifted out in the upcoming segment, MSB first
        case (w_nxt_byte)
            2'd0:    w_tx_byte = w_nxt_ph2 ? (DATA_W'(DEV_ID) | DATA_W'(1)) : DATA_W'(DEV_ID);
            2'd1:    w_tx_byte = r_addr;
            default: w_tx_byte = r_wdata;
        endcase
        w_tx_shift = w_tx_byte << w_nxt_bit;
        w_tx_bit   = w_tx_shift[DATA_W-1];

        case (w_nxt_state)
            START: begin
                w_nxt_sio_c     = 1'b1;
                w_nxt_sio_d_en  = 1'b1;
                w_nxt_sio_d_out = (w_nxt_cnt < CNT_W'(2 * Q));
            end
            WBYTE: begin
                w_nxt_sio_c = (w_nxt_cnt >= CNT_W'(2 * Q));
                if (w_nxt_cnt == CNT_W'(Q)) begin
                    if (w_nxt_bit < BIT_W'(DATA_W)) begin
                        w_nxt_sio_d_en  = 1'b1;
                        w_nxt_sio_d_out = w_tx_bit;
                    end else begin
                        w_nxt_sio_d_en  = 1'b0;
                        w_nxt_sio_d_out = 1'b1;
                    end
                end
            end
            RBYTE: begin
                w_nxt_sio_c = (w_nxt_cnt >= CNT_W'(2 * Q));
                if (w_nxt_cnt == CNT_W'(Q)) begin
                    w_nxt_sio_d_en  = (w_nxt_bit == BIT_W'(DATA_W));
                    w_nxt_sio_d_out = 1'b1;
                end
            end
            STOP: begin
                w_nxt_sio_c     = (w_nxt_cnt >= CNT_W'(Q));
                w_nxt_sio_d_en  = 1'b1;
                w_nxt_sio_d_out = (w_nxt_cnt >= CNT_W'(2 * Q));
            end
            default: begin
                w_nxt_sio_c     = 1'b1;
                w_nxt_sio_d_en  = 1'b0;
                w_nxt_sio_d_out = 1'b1;
            end
        endcase
    end

    // FSM state, segment counters and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_byte      <= 2'd0;
            r_ph2       <= 1'b0;
            r_sio_c     <= 1'b1;
            r_sio_d_out <= 1'b1;
            r_sio_d_en  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_bit       <= w_nxt_bit;
            r_byte      <= w_nxt_byte;
            r_ph2       <= w_nxt_ph2;
            r_sio_c     <= w_nxt_sio_c;
            r_sio_d_out <= w_nxt_sio_d_out;
            r_sio_d_en  <= w_nxt_sio_d_en;
        end
    end

    // Request capture, read-data shift-in and completion strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rx        <= '0;
            r_rdata     <= '0;
            r_rdata_vld <= 1'b0;
        end else begin
            r_rdata_vld <= 1'b0;
            if (w_accept) begin
                r_rd    <= rd_en && !wr_en;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if ((r_state == RBYTE) && (r_cnt == CNT_W'(3 * Q)) && (r_bit < BIT_W'(DATA_W))) begin
                r_rx <= {r_rx[DATA_W-2:0], sio_d_in};
            end
            if ((r_state == GAP) && w_seg_end && r_rd && r_ph2) begin
                r_rdata     <= r_rx;
                r_rdata_vld <= 1'b1;
            end
        end
    end

endmodule
